// File: rtl/frm_pkg.sv
// Shared widths, FSM encoding and a saturating-increment helper for the
// frame-geometry checker.
package frm_pkg;

  localparam int CNT_W  = 12;
  localparam int FCNT_W = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_SYNC     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_IN_FRAME = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frm_check_if.sv
// Video timing bundle from the upstream frame generator: sample enable plus
// line-valid and frame-valid.
interface frm_check_if;

  logic en;
  logic data_in_lval;
  logic data_in_fval;

  modport master (output en, data_in_lval, data_in_fval);
  modport slave  (input  en, data_in_lval, data_in_fval);

endinterface

// File: rtl/edge_det.sv
// Registered copy of a single-bit input, updated only on enabled cycles;
// rise/fall are qualified by the same enable.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

  assign rise = en &  d & ~q;
  assign fall = en & ~d &  q;

endmodule

// File: rtl/frm_check.sv
// Measures line width and frame height of a lval/fval video stream, flags
// deviations from the configured geometry and counts completed frames.
module frm_check
  import frm_pkg::*;
#(
  parameter int FRAME_WIDTH  = 1920,
  parameter int FRAME_HEIGHT = 1080
) (
  input  logic              pixclk,
  input  logic              rst_n,
  frm_check_if.slave        vid,
  input  logic              clr_err,
  output logic [CNT_W-1:0]  meas_width,
  output logic [CNT_W-1:0]  meas_height,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              frame_done,
  output logic              width_err,
  output logic              height_err
);

  // Both parameters must fit in CNT_W bits; larger values are a configuration error.
  localparam logic [CNT_W-1:0] EXP_W = CNT_W'(FRAME_WIDTH);
  localparam logic [CNT_W-1:0] EXP_H = CNT_W'(FRAME_HEIGHT);

  logic en, lval, fval;
  assign en   = vid.en;
  assign lval = vid.data_in_lval;
  assign fval = vid.data_in_fval;

  logic lval_q, lval_rise, lval_fall;
  logic fval_q, fval_rise, fval_fall;

  edge_det u_lval_edge (
    .clk  (pixclk),
    .rst_n(rst_n),
    .en   (en),
    .d    (lval),
    .q    (lval_q),
    .rise (lval_rise),
    .fall (lval_fall)
  );

  edge_det u_fval_edge (
    .clk  (pixclk),
    .rst_n(rst_n),
    .en   (en),
    .d    (fval),
    .q    (fval_q),
    .rise (fval_rise),
    .fall (fval_fall)
  );

  logic unused_edges;
  assign unused_edges = lval_rise ^ fval_q;

  state_e state, state_nx;
  logic   frame_start;
  logic   in_frame;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SYNC;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_SYNC:     if (en && !fval) state_nx = ST_WAIT_SOF;
      ST_WAIT_SOF: if (fval_rise)   state_nx = ST_IN_FRAME;
      ST_IN_FRAME: if (fval_fall)   state_nx = ST_WAIT_SOF;
      default:                      state_nx = ST_SYNC;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    in_frame    = 1'b0;
    unique case (state)
      ST_WAIT_SOF: frame_start = fval_rise;
      ST_IN_FRAME: in_frame    = 1'b1;
      default: ;
    endcase
  end

  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic             count_pix;
  logic             line_end;
  logic             frame_end;
  logic [CNT_W-1:0] height_now;
  logic             width_bad;
  logic             height_bad;
  logic             clr;

  // A line still open when fval drops is closed in that same cycle so it
  // is included in the frame height.
  assign count_pix  = in_frame & en & lval & fval;
  assign line_end   = in_frame & (lval_fall | (fval_fall & lval_q & lval));
  assign frame_end  = in_frame & fval_fall;
  assign height_now = line_end ? sat_inc(line_cnt) : line_cnt;
  assign width_bad  = line_end  & (pix_cnt    != EXP_W);
  assign height_bad = frame_end & (height_now != EXP_H);
  assign clr        = en & clr_err;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (frame_start) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (line_end) begin
        pix_cnt  <= '0;
        line_cnt <= sat_inc(line_cnt);
      end else if (count_pix) begin
        pix_cnt  <= sat_inc(pix_cnt);
      end
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      meas_width  <= '0;
      meas_height <= '0;
      frame_cnt   <= '0;
      frame_done  <= 1'b0;
      width_err   <= 1'b0;
      height_err  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (line_end) begin
        meas_width <= pix_cnt;
      end
      if (frame_end) begin
        meas_height <= height_now;
        frame_cnt   <= frame_cnt + 1'b1;
      end
      // A violation in the same cycle as a clear leaves the flag set.
      width_err  <= (width_err  & ~clr) | width_bad;
      height_err <= (height_err & ~clr) | height_bad;
    end
  end

endmodule
